// File: rtl/arbitro_memoria_pkg.sv
// Shared constants for the CPUCR memory arbiter: FSM encodings, port IDs
// and default bus widths.
package arbitro_memoria_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef logic [2:0] state_t;

  // 3-bit state encodings, kept as plain constants so older code can share them
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ADDR  = 3'd1;
  localparam logic [2:0] S_RD_CAP   = 3'd2;
  localparam logic [2:0] S_WR_SETUP = 3'd3;
  localparam logic [2:0] S_WR_STRB  = 3'd4;
  localparam logic [2:0] S_WR_HOLD  = 3'd5;

  // Requester identifiers, also used as the round-robin pointer value
  localparam logic P_CPU = 1'b0;
  localparam logic P_DMA = 1'b1;

  // The cycle in which an access reports completion to its requester
  function automatic logic is_done_state(input state_t s);
    return (s == S_RD_CAP) || (s == S_WR_HOLD);
  endfunction

endpackage

// File: rtl/arbitro_memoria_if.sv
// One requester port of the memory arbiter (CPU or DMA/loader).
// The requester holds req until it sees the one-cycle done pulse.
interface arbitro_memoria_if
  import arbitro_memoria_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              done;

  modport master (output req, output we, output addr, output wdata, input done);
  modport slave  (input req, input we, input addr, input wdata, output done);

endinterface

// File: rtl/arbitro_memoria_rr_pick.sv
// Two-input round-robin picker: a lone requester wins outright, and when both
// ask at once the port that was not granted last wins.
module rr_pick
  import arbitro_memoria_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       any
);

  // Pure combinational choice; the caller owns and updates the pointer
  always_comb begin
    any    = |req;
    gnt_id = P_CPU;
    case (req)
      2'b01:   gnt_id = P_CPU;
      2'b10:   gnt_id = P_DMA;
      2'b11:   gnt_id = ~last;
      default: gnt_id = P_CPU;
    endcase
  end

endmodule

// File: rtl/arbitro_memoria.sv
// Arbiter and bus sequencer sharing the CPUCR main memory between the CPU and
// the DMA/loader. Each access is split into LE phases so the strobe never
// glitches, and the Datos driver is only enabled while LE is low.
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  arbitro_memoria_if.slave  cpu,
  arbitro_memoria_if.slave  dma,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] Direccion,
  inout  wire  [DATA_W-1:0] Datos,
  output logic              LE
);

  logic [2:0]        state_q, state_d;
  logic              last_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              le_q;
  logic              cpu_done_q;
  logic              dma_done_q;

  logic              gnt_id;
  logic              any_req;
  logic              grant;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              datos_oe;

  rr_pick u_pick (
    .req    ({dma.req, cpu.req}),
    .last   (last_q),
    .gnt_id (gnt_id),
    .any    (any_req)
  );

  // Route the winning requester's command toward the latch registers
  always_comb begin
    win_we    = cpu.we;
    win_addr  = cpu.addr;
    win_wdata = cpu.wdata;
    if (gnt_id == P_DMA) begin
      win_we    = dma.we;
      win_addr  = dma.addr;
      win_wdata = dma.wdata;
    end
  end

  // Sequence the access; requests are only looked at while IDLE, so a dropped
  // req mid-access still runs to completion
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = win_we ? S_WR_SETUP : S_RD_ADDR;
        end
      end
      S_RD_ADDR:  state_d = S_RD_CAP;
      S_RD_CAP:   state_d = S_IDLE;
      S_WR_SETUP: state_d = S_WR_STRB;
      S_WR_STRB:  state_d = S_WR_HOLD;
      S_WR_HOLD:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State, latched command, registered LE strobe and done pulses. The access
  // direction lives in the read/write branch of the state, so no separate we
  // latch is kept. Read data is captured at the end of RD_ADDR, after a full
  // cycle of stable address, so it is already valid during the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_q     <= P_DMA;
      owner_q    <= P_CPU;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      le_q       <= 1'b1;
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q  <= gnt_id;
        owner_q <= gnt_id;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
      end
      if (state_q == S_RD_ADDR) begin
        rdata_q <= Datos;
      end
      le_q       <= (state_d != S_WR_STRB);
      cpu_done_q <= (owner_q == P_CPU) && is_done_state(state_d);
      dma_done_q <= (owner_q == P_DMA) && is_done_state(state_d);
    end
  end

  // Driver follows the registered strobe, so it can never overlap LE high
  // when the memory itself is driving the bus
  assign datos_oe  = ~le_q & (state_q == S_WR_STRB);
  assign Datos     = datos_oe ? wdata_q : {DATA_W{1'bz}};

  assign Direccion = addr_q;
  assign LE        = le_q;
  assign rdata     = rdata_q;
  assign cpu.done  = cpu_done_q;
  assign dma.done  = dma_done_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench for arbitro_memoria: a behavioural memory on the bus,
// a table of single-port accesses, hand-written multi-cycle corner cases and
// a randomized two-port phase checked against a reference memory image.
module tb_arbitro_memoria;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rdata;
  logic [15:0] Direccion;
  wire  [7:0]  Datos;
  logic        LE;

  arbitro_memoria_if cpuBus ();
  arbitro_memoria_if dmaBus ();

  arbitro_memoria dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpuBus),
    .dma       (dmaBus),
    .rdata     (rdata),
    .Direccion (Direccion),
    .Datos     (Datos),
    .LE        (LE)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int leFalls = 0;

  logic [7:0] mem    [0:65535];
  logic [7:0] refMem [0:65535];

  // Behavioural memory: drives the bus while LE is high, writes on LE fall
  assign Datos = LE ? mem[Direccion] : 8'hzz;

  always @(negedge LE) begin
    leFalls++;
    #1;
    mem[Direccion] = Datos;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // The arbiter must never drive Datos while LE is high
  always @(negedge clk) begin
    checkOutput("busOe", 32'(dut.datos_oe & LE), 32'd0);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // One access on one port: raise req, wait for done (bounded), drop req.
  // With scramble set the port inputs change after the grant edge to show the
  // arbiter works from its latched copy.
  task automatic applyStimulus(input bit port, input bit we, input logic [15:0] addr,
                               input logic [7:0] wdata, input bit scramble,
                               output int lat, output logic [7:0] rd,
                               output int leLow, output int otherDone,
                               output logic [15:0] dirAtDone, output bit timedOut);
    @(posedge clk); #1;
    if (port == 1'b0) begin
      cpuBus.req = 1'b1; cpuBus.we = we; cpuBus.addr = addr; cpuBus.wdata = wdata;
    end else begin
      dmaBus.req = 1'b1; dmaBus.we = we; dmaBus.addr = addr; dmaBus.wdata = wdata;
    end
    lat = 0; leLow = 0; otherDone = 0; rd = 8'h00; dirAtDone = 16'h0000; timedOut = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (scramble && lat == 1) begin
        if (port == 1'b0) begin
          cpuBus.addr = ~addr; cpuBus.wdata = ~wdata;
        end else begin
          dmaBus.addr = ~addr; dmaBus.wdata = ~wdata;
        end
      end
      if (!LE) leLow++;
      if ((port == 1'b0) ? dmaBus.done : cpuBus.done) otherDone++;
      if ((port == 1'b0) ? cpuBus.done : dmaBus.done) begin
        rd = rdata;
        dirAtDone = Direccion;
        timedOut = 1'b0;
        break;
      end
    end
    if (port == 1'b0) cpuBus.req = 1'b0;
    else              dmaBus.req = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_LE"}, 32'(LE), 32'd1);
    checkOutput({tag, "_Direccion"}, 32'(Direccion), 32'd0);
    checkOutput({tag, "_rdata"}, 32'(rdata), 32'd0);
    checkOutput({tag, "_cpuDone"}, 32'(cpuBus.done), 32'd0);
    checkOutput({tag, "_dmaDone"}, 32'(dmaBus.done), 32'd0);
  endtask

  // Randomized traffic from one port; expectations come from refMem and the
  // service bound: at most one foreign access plus an idle gap ahead of ours
  task automatic randPort(input bit port, input int n);
    int lat, leLow, otherDone, idle;
    logic [7:0] rd;
    logic [15:0] dir;
    bit to;
    bit we;
    logic [15:0] addr;
    logic [7:0] wdata;
    for (int k = 0; k < n; k++) begin
      idle = int'($urandom_range(0, 3));
      repeat (idle) @(posedge clk);
      we    = 1'($urandom_range(0, 1));
      addr  = 16'(16'h0010 + 16'($urandom_range(0, 7)));
      wdata = 8'($urandom);
      applyStimulus(port, we, addr, wdata, 1'b0, lat, rd, leLow, otherDone, dir, to);
      checkOutput("randTimeout", 32'(to), 32'd0);
      checkOutput("randLatencyInRange",
                  32'((lat >= (we ? 3 : 2)) && (lat <= 8)), 32'd1);
      checkOutput("randDireccion", 32'(dir), 32'(addr));
      if (we) begin
        checkOutput("randMemWrite", 32'(mem[addr]), 32'(wdata));
        refMem[addr] = wdata;
      end else begin
        checkOutput("randRead", 32'(rd), 32'(refMem[addr]));
      end
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  expRd;
    int          expLat;
    int          expLeLow;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int lat, leLow, otherDone, nDone, savedFalls;
    logic [7:0] rd, lastRd;
    logic [15:0] dir;
    bit to;
    bit donePort [4];
    logic [7:0] doneData [4];
    int doneCycle [4];
    bit expPort [4];
    logic [7:0] expData [4];

    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'h00;
      refMem[a] = 8'h00;
    end
    cpuBus.req = 1'b0; cpuBus.we = 1'b0; cpuBus.addr = 16'h0; cpuBus.wdata = 8'h0;
    dmaBus.req = 1'b0; dmaBus.we = 1'b0; dmaBus.addr = 16'h0; dmaBus.wdata = 8'h0;

    vecs[0]  = '{1'b0, 1'b1, 16'h0020, 8'hA5, 8'h00, 3, 1};
    vecs[1]  = '{1'b0, 1'b0, 16'h0020, 8'h00, 8'hA5, 2, 0};
    vecs[2]  = '{1'b1, 1'b1, 16'hFFFF, 8'h3C, 8'h00, 3, 1};
    vecs[3]  = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h3C, 2, 0};
    vecs[4]  = '{1'b0, 1'b1, 16'h0001, 8'h5A, 8'h00, 3, 1};
    vecs[5]  = '{1'b1, 1'b1, 16'h0002, 8'hC3, 8'h00, 3, 1};
    vecs[6]  = '{1'b0, 1'b0, 16'h0002, 8'h00, 8'hC3, 2, 0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0001, 8'h00, 8'h5A, 2, 0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0000, 8'hFF, 8'h00, 3, 1};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 2, 0};
    vecs[10] = '{1'b1, 1'b0, 16'h0020, 8'h00, 8'hA5, 2, 0};
    vecs[11] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h00, 3, 1};
    vecs[12] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h00, 2, 0};

    doReset();
    checkResetState("reset");

    // Single-port accesses from the table
    lastRd = 8'h00;
    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, 1'b1,
                    lat, rd, leLow, otherDone, dir, to);
      checkOutput($sformatf("vec%0d_timeout", v), 32'(to), 32'd0);
      checkOutput($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].expLat));
      checkOutput($sformatf("vec%0d_leLowCycles", v), 32'(leLow), 32'(vecs[v].expLeLow));
      checkOutput($sformatf("vec%0d_otherDone", v), 32'(otherDone), 32'd0);
      checkOutput($sformatf("vec%0d_Direccion", v), 32'(dir), 32'(vecs[v].addr));
      if (vecs[v].we) begin
        checkOutput($sformatf("vec%0d_memWrite", v), 32'(mem[vecs[v].addr]),
                    32'(vecs[v].wdata));
        checkOutput($sformatf("vec%0d_rdataHeld", v), 32'(rd), 32'(lastRd));
        refMem[vecs[v].addr] = vecs[v].wdata;
      end else begin
        checkOutput($sformatf("vec%0d_rdata", v), 32'(rd), 32'(vecs[v].expRd));
        lastRd = vecs[v].expRd;
      end
    end

    // Both ports reading continuously from a fresh reset: CPU, DMA, CPU, DMA
    doReset();
    checkResetState("reset2");
    cpuBus.we = 1'b0; cpuBus.addr = 16'h0001; cpuBus.req = 1'b1;
    dmaBus.we = 1'b0; dmaBus.addr = 16'h0002; dmaBus.req = 1'b1;
    expPort = '{1'b0, 1'b1, 1'b0, 1'b1};
    expData = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};
    nDone = 0;
    for (int c = 1; c <= 30 && nDone < 4; c++) begin
      @(posedge clk); #1;
      if (cpuBus.done && dmaBus.done) checkOutput("bothDoneTogether", 32'd1, 32'd0);
      if (cpuBus.done || dmaBus.done) begin
        donePort[nDone]  = dmaBus.done;
        doneData[nDone]  = rdata;
        doneCycle[nDone] = c;
        nDone++;
      end
    end
    cpuBus.req = 1'b0;
    dmaBus.req = 1'b0;
    checkOutput("rrDoneCount", 32'(nDone), 32'd4);
    for (int i = 0; i < nDone; i++) begin
      checkOutput($sformatf("rrPort%0d", i), 32'(donePort[i]), 32'(expPort[i]));
      checkOutput($sformatf("rrData%0d", i), 32'(doneData[i]), 32'(expData[i]));
      checkOutput($sformatf("rrCycle%0d", i), 32'(doneCycle[i]), 32'(2 + 3 * i));
    end

    // Reset during WR_SETUP: the write must never strobe
    @(posedge clk); #1;
    @(posedge clk); #1;
    savedFalls = leFalls;
    cpuBus.we = 1'b1; cpuBus.addr = 16'h0005; cpuBus.wdata = 8'h77; cpuBus.req = 1'b1;
    @(posedge clk); #1;
    checkOutput("setupDireccion", 32'(Direccion), 32'h0005);
    checkOutput("setupLE", 32'(LE), 32'd1);
    reset = 1'b1;
    cpuBus.req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    checkResetState("resetInSetup");
    nDone = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (cpuBus.done || dmaBus.done || !LE) nDone++;
    end
    checkOutput("abortQuiet", 32'(nDone), 32'd0);
    checkOutput("abortLeFalls", 32'(leFalls - savedFalls), 32'd0);
    checkOutput("abortMemUnchanged", 32'(mem[16'h0005]), 32'h00);
    applyStimulus(1'b0, 1'b0, 16'h0005, 8'h00, 1'b0, lat, rd, leLow, otherDone, dir, to);
    checkOutput("abortReadTimeout", 32'(to), 32'd0);
    checkOutput("abortReadLatency", 32'(lat), 32'd2);
    checkOutput("abortReadData", 32'(rd), 32'h00);

    // Randomized contention between both ports
    fork
      randPort(1'b0, 40);
      randPort(1'b1, 40);
    join

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
